// File: rtl/id_ex.sv
// ID/EX pipeline register: captures decoded controls, operands and specifiers every cycle,
// zeroing only the control fields to insert a bubble on a load-use stall or branch flush.
module id_ex (
    input  logic        ID_Hazard_lwstall,
    input  logic        ID_Hazard_Branch,
    input  logic        Branch_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        Jump_in,
    input  logic        RegWrite_in,
    input  logic        MemtoReg_in,
    input  logic        RegDst_in,
    input  logic        ALUSrc_in,
    input  logic [1:0]  ALUOp_in,
    input  logic [31:0] jump_addr_in,
    input  logic [31:0] PC_plus4_in,
    input  logic [31:0] reg_read_data_1_in,
    input  logic [31:0] reg_read_data_2_in,
    input  logic [31:0] immi_sign_extended_in,
    input  logic [4:0]  IF_ID_RegisterRs_in,
    input  logic [4:0]  IF_ID_RegisterRt_in,
    input  logic [4:0]  IF_ID_RegisterRd_in,
    input  logic [5:0]  IF_ID_funct_in,
    input  logic        clk,
    input  logic        rst,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic        Branch_out,
    output logic        MemRead_out,
    output logic        MemWrite_out,
    output logic        Jump_out,
    output logic        RegDst_out,
    output logic        ALUSrc_out,
    output logic [1:0]  ALUOp_out,
    output logic [31:0] jump_addr_out,
    output logic [31:0] PC_plus4_out,
    output logic [31:0] reg_read_data_1_out,
    output logic [31:0] reg_read_data_2_out,
    output logic [31:0] immi_sign_extended_out,
    output logic [4:0]  IF_ID_RegisterRs_out,
    output logic [4:0]  IF_ID_RegisterRt_out,
    output logic [4:0]  IF_ID_RegisterRd_out,
    output logic [5:0]  IF_ID_funct_out
);

    typedef struct packed {
        logic       reg_write;
        logic       memto_reg;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       jump;
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

    logic  bubble;
    ctrl_t ctrl_in, ctrl_q;

    assign bubble  = ID_Hazard_lwstall | ID_Hazard_Branch;
    assign ctrl_in = '{reg_write: RegWrite_in, memto_reg: MemtoReg_in, branch: Branch_in,
                       mem_read: MemRead_in, mem_write: MemWrite_in, jump: Jump_in,
                       reg_dst: RegDst_in, alu_src: ALUSrc_in, alu_op: ALUOp_in};

    // Control path: a bubble clears every enable so the EX/MEM/WB stages do nothing.
    always_ff @(posedge clk) begin
        if (rst || bubble)
            ctrl_q <= '0;
        else
            ctrl_q <= ctrl_in;
    end

    // Data path keeps capturing during a bubble; without enables downstream it is inert.
    always_ff @(posedge clk) begin
        if (rst) begin
            jump_addr_out          <= '0;
            PC_plus4_out           <= '0;
            reg_read_data_1_out    <= '0;
            reg_read_data_2_out    <= '0;
            immi_sign_extended_out <= '0;
            IF_ID_RegisterRs_out   <= '0;
            IF_ID_RegisterRt_out   <= '0;
            IF_ID_RegisterRd_out   <= '0;
            IF_ID_funct_out        <= '0;
        end else begin
            jump_addr_out          <= jump_addr_in;
            PC_plus4_out           <= PC_plus4_in;
            reg_read_data_1_out    <= reg_read_data_1_in;
            reg_read_data_2_out    <= reg_read_data_2_in;
            immi_sign_extended_out <= immi_sign_extended_in;
            IF_ID_RegisterRs_out   <= IF_ID_RegisterRs_in;
            IF_ID_RegisterRt_out   <= IF_ID_RegisterRt_in;
            IF_ID_RegisterRd_out   <= IF_ID_RegisterRd_in;
            IF_ID_funct_out        <= IF_ID_funct_in;
        end
    end

    assign RegWrite_out = ctrl_q.reg_write;
    assign MemtoReg_out = ctrl_q.memto_reg;
    assign Branch_out   = ctrl_q.branch;
    assign MemRead_out  = ctrl_q.mem_read;
    assign MemWrite_out = ctrl_q.mem_write;
    assign Jump_out     = ctrl_q.jump;
    assign RegDst_out   = ctrl_q.reg_dst;
    assign ALUSrc_out   = ctrl_q.alu_src;
    assign ALUOp_out    = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_ex.sv
// Randomized self-checking bench for id_ex against a stage-level model of the ID/EX register.
module tb_id_ex;

    typedef struct packed {
        logic        branch, mem_read, mem_write, jump, reg_write, memto_reg, reg_dst, alu_src;
        logic [1:0]  alu_op;
        logic [31:0] jump_addr, pc4, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  funct;
    } bundle_t;

    logic    clk = 1'b0;
    logic    rst, lw, br;
    bundle_t cur, obs, exp_b;
    int      errors = 0;
    int      checks = 0;

    logic        RegWrite_out, MemtoReg_out, Branch_out, MemRead_out, MemWrite_out;
    logic        Jump_out, RegDst_out, ALUSrc_out;
    logic [1:0]  ALUOp_out;
    logic [31:0] jump_addr_out, PC_plus4_out, reg_read_data_1_out, reg_read_data_2_out;
    logic [31:0] immi_sign_extended_out;
    logic [4:0]  IF_ID_RegisterRs_out, IF_ID_RegisterRt_out, IF_ID_RegisterRd_out;
    logic [5:0]  IF_ID_funct_out;

    always #5 clk = ~clk;

    id_ex dut (
        .ID_Hazard_lwstall(lw), .ID_Hazard_Branch(br),
        .Branch_in(cur.branch), .MemRead_in(cur.mem_read), .MemWrite_in(cur.mem_write),
        .Jump_in(cur.jump), .RegWrite_in(cur.reg_write), .MemtoReg_in(cur.memto_reg),
        .RegDst_in(cur.reg_dst), .ALUSrc_in(cur.alu_src), .ALUOp_in(cur.alu_op),
        .jump_addr_in(cur.jump_addr), .PC_plus4_in(cur.pc4),
        .reg_read_data_1_in(cur.rd1), .reg_read_data_2_in(cur.rd2),
        .immi_sign_extended_in(cur.imm),
        .IF_ID_RegisterRs_in(cur.rs), .IF_ID_RegisterRt_in(cur.rt),
        .IF_ID_RegisterRd_in(cur.rd), .IF_ID_funct_in(cur.funct),
        .clk(clk), .rst(rst),
        .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out), .Branch_out(Branch_out),
        .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out), .Jump_out(Jump_out),
        .RegDst_out(RegDst_out), .ALUSrc_out(ALUSrc_out), .ALUOp_out(ALUOp_out),
        .jump_addr_out(jump_addr_out), .PC_plus4_out(PC_plus4_out),
        .reg_read_data_1_out(reg_read_data_1_out), .reg_read_data_2_out(reg_read_data_2_out),
        .immi_sign_extended_out(immi_sign_extended_out),
        .IF_ID_RegisterRs_out(IF_ID_RegisterRs_out), .IF_ID_RegisterRt_out(IF_ID_RegisterRt_out),
        .IF_ID_RegisterRd_out(IF_ID_RegisterRd_out), .IF_ID_funct_out(IF_ID_funct_out)
    );

    assign obs = {Branch_out, MemRead_out, MemWrite_out, Jump_out, RegWrite_out, MemtoReg_out,
                  RegDst_out, ALUSrc_out, ALUOp_out, jump_addr_out, PC_plus4_out,
                  reg_read_data_1_out, reg_read_data_2_out, immi_sign_extended_out,
                  IF_ID_RegisterRs_out, IF_ID_RegisterRt_out, IF_ID_RegisterRd_out,
                  IF_ID_funct_out};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // What EX should see after an edge: nothing on reset, inputs minus their enables on a bubble.
    function automatic bundle_t model(input bundle_t i, input logic r, input logic h1, input logic h2);
        bundle_t m;
        if (r) return '0;
        m = i;
        if (h1 || h2) begin
            {m.branch, m.mem_read, m.mem_write, m.jump} = 4'b0;
            {m.reg_write, m.memto_reg, m.reg_dst, m.alu_src} = 4'b0;
            m.alu_op = 2'b00;
        end
        return m;
    endfunction

    task automatic compare_all(input string tag, input bundle_t o, input bundle_t e);
        chk({tag, ".ctrl"}, {22'd0, o.branch, o.mem_read, o.mem_write, o.jump, o.reg_write,
             o.memto_reg, o.reg_dst, o.alu_src, o.alu_op},
            {22'd0, e.branch, e.mem_read, e.mem_write, e.jump, e.reg_write,
             e.memto_reg, e.reg_dst, e.alu_src, e.alu_op});
        chk({tag, ".jaddr"}, o.jump_addr, e.jump_addr);
        chk({tag, ".pc4"},   o.pc4, e.pc4);
        chk({tag, ".rd1"},   o.rd1, e.rd1);
        chk({tag, ".rd2"},   o.rd2, e.rd2);
        chk({tag, ".imm"},   o.imm, e.imm);
        chk({tag, ".regs"},  {17'd0, o.rs, o.rt, o.rd}, {17'd0, e.rs, e.rt, e.rd});
        chk({tag, ".funct"}, {26'd0, o.funct}, {26'd0, e.funct});
    endtask

    task automatic step(input string tag);
        exp_b = model(cur, rst, lw, br);
        @(posedge clk);
        #1;
        compare_all(tag, obs, exp_b);
    endtask

    task automatic randomize_inputs();
        logic [191:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        cur = r[190:0];
    endtask

    task automatic all_ctrl_set();
        randomize_inputs();
        {cur.branch, cur.mem_read, cur.mem_write, cur.jump} = 4'hF;
        {cur.reg_write, cur.memto_reg, cur.reg_dst, cur.alu_src} = 4'hF;
        cur.alu_op = 2'b10;
    endtask

    initial begin
        rst = 1'b1; lw = 1'b0; br = 1'b0;
        cur = '1;
        @(negedge clk);
        step("reset");
        chk("reset.jaddr_zero", jump_addr_out, 32'd0);
        rst = 1'b0;
        step("first_capture");

        cur.rd1 = 32'h12153524;
        step("example");
        chk("example.rd1", reg_read_data_1_out, 32'h12153524);

        for (int n = 0; n < 2000; n++) begin
            randomize_inputs();
            step("pass");
        end

        all_ctrl_set(); lw = 1'b1;
        step("lwstall");
        chk("lwstall.regwrite", {31'd0, RegWrite_out}, 32'd0);
        all_ctrl_set(); lw = 1'b0;
        step("lwstall_after");
        chk("lwstall_after.aluop", {30'd0, ALUOp_out}, 32'd2);

        all_ctrl_set(); br = 1'b1;
        step("flush");
        all_ctrl_set(); br = 1'b0;
        step("flush_after");

        all_ctrl_set(); lw = 1'b1; br = 1'b1;
        step("both");
        rst = 1'b1;
        step("rst_both");
        rst = 1'b0; lw = 1'b0; br = 1'b0;
        all_ctrl_set();
        step("rst_both_after");

        // Mid-cycle wiggles of rst and inputs must not reach the outputs before the next edge.
        for (int n = 0; n < 20; n++) begin
            rst = 1'b1;
            randomize_inputs();
            #3;
            compare_all("async", obs, exp_b);
            rst = n[0];
            lw  = 1'($urandom_range(0, 1));
            br  = 1'($urandom_range(0, 1));
            step("async_edge");
        end

        for (int n = 0; n < 500; n++) begin
            randomize_inputs();
            rst = ($urandom_range(0, 15) == 0);
            lw  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 3) == 0);
            step("mixed");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
